// File: rtl/matrix_dot_product_seq.sv
// Row/column sequencer with a serial multiply-accumulate dot-product engine.
// Define DOT_PRODUCT_SIGNED_EN for two's-complement elements; the default build is unsigned.
module matrix_dot_product_seq #(
    parameter int DATA_WIDTH      = 16,
    parameter int ROW_COL_SIZE    = 16,
    parameter int MATRIX_SIZE     = 16,
    parameter int NUM_SELECT_BITS = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1,
    parameter int ACC_WIDTH       = 2*DATA_WIDTH + $clog2(ROW_COL_SIZE) + 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [NUM_SELECT_BITS-1:0]         row_select,
    output logic [NUM_SELECT_BITS-1:0]         col_select,
    input  logic [ROW_COL_SIZE*DATA_WIDTH-1:0] row_data,
    input  logic [ROW_COL_SIZE*DATA_WIDTH-1:0] col_data,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [ACC_WIDTH-1:0]               result_data,
    output logic [NUM_SELECT_BITS-1:0]         result_row,
    output logic [NUM_SELECT_BITS-1:0]         result_col
);

    localparam int VEC_W  = ROW_COL_SIZE*DATA_WIDTH;
    localparam int CNT_W  = (ROW_COL_SIZE > 1) ? $clog2(ROW_COL_SIZE) : 1;
    localparam int PROD_W = 2*DATA_WIDTH;
    localparam int EXT_W  = ACC_WIDTH - PROD_W;
    localparam logic [NUM_SELECT_BITS-1:0] LAST_IDX = NUM_SELECT_BITS'(MATRIX_SIZE-1);
    localparam logic [CNT_W-1:0]           LAST_K   = CNT_W'(ROW_COL_SIZE-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [VEC_W-1:0]           row_vec_q, row_vec_d;
    logic [VEC_W-1:0]           col_vec_q, col_vec_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]           k_q, k_d;
    logic [NUM_SELECT_BITS-1:0] row_idx_q, row_idx_d;
    logic [NUM_SELECT_BITS-1:0] col_idx_q, col_idx_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       valid_q, valid_d;
    logic [ACC_WIDTH-1:0]       res_data_q, res_data_d;
    logic [NUM_SELECT_BITS-1:0] res_row_q, res_row_d;
    logic [NUM_SELECT_BITS-1:0] res_col_q, res_col_d;

    logic [DATA_WIDTH-1:0] row_elem [ROW_COL_SIZE];
    logic [DATA_WIDTH-1:0] col_elem [ROW_COL_SIZE];

    generate
        for (genvar gi = 0; gi < ROW_COL_SIZE; gi++) begin : g_unpack
            assign row_elem[gi] = row_vec_q[gi*DATA_WIDTH +: DATA_WIDTH];
            assign col_elem[gi] = col_vec_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [DATA_WIDTH-1:0] cur_a, cur_b;
    logic [PROD_W-1:0]     a_ext, b_ext, prod;
    logic [ACC_WIDTH-1:0]  prod_ext, acc_sum;

    assign cur_a = row_elem[k_q];
    assign cur_b = col_elem[k_q];

    // Operands are widened to the product width first, so the low PROD_W bits
    // of the product are exact for both signed and unsigned interpretation.
`ifdef DOT_PRODUCT_SIGNED_EN
    assign a_ext    = {{DATA_WIDTH{cur_a[DATA_WIDTH-1]}}, cur_a};
    assign b_ext    = {{DATA_WIDTH{cur_b[DATA_WIDTH-1]}}, cur_b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};
`else
    assign a_ext    = {{DATA_WIDTH{1'b0}}, cur_a};
    assign b_ext    = {{DATA_WIDTH{1'b0}}, cur_b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{EXT_W{1'b0}}, prod};
`endif

    assign acc_sum = acc_q + prod_ext;

    always_comb begin
        state_d    = state_q;
        row_vec_d  = row_vec_q;
        col_vec_d  = col_vec_q;
        acc_d      = acc_q;
        k_d        = k_q;
        row_idx_d  = row_idx_q;
        col_idx_d  = col_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        res_data_d = res_data_q;
        res_row_d  = res_row_q;
        res_col_d  = res_col_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_idx_d = '0;
                    col_idx_d = '0;
                    busy_d    = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                row_vec_d = row_data;
                col_vec_d = col_data;
                acc_d     = '0;
                k_d       = '0;
                state_d   = MAC;
            end
            MAC: begin
                acc_d = acc_sum;
                if (k_q == LAST_K) begin
                    res_data_d = acc_sum;
                    res_row_d  = row_idx_q;
                    res_col_d  = col_idx_q;
                    valid_d    = 1'b1;
                    state_d    = OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            OUT: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    if (row_idx_q == LAST_IDX && col_idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Row-major walk: column wraps into the next row.
                        if (col_idx_q == LAST_IDX) begin
                            col_idx_d = '0;
                            row_idx_d = row_idx_q + 1'b1;
                        end else begin
                            col_idx_d = col_idx_q + 1'b1;
                        end
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            row_vec_q  <= '0;
            col_vec_q  <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            row_idx_q  <= '0;
            col_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            res_data_q <= '0;
            res_row_q  <= '0;
            res_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_vec_q  <= row_vec_d;
            col_vec_q  <= col_vec_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            row_idx_q  <= row_idx_d;
            col_idx_q  <= col_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            res_data_q <= res_data_d;
            res_row_q  <= res_row_d;
            res_col_q  <= res_col_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign row_select   = row_idx_q;
    assign col_select   = col_idx_q;
    assign result_valid = valid_q;
    assign result_data  = res_data_q;
    assign result_row   = res_row_q;
    assign result_col   = res_col_q;

endmodule

// File: tb/tb_matrix_dot_product_seq.sv
// Scoreboard bench for matrix_dot_product_seq with a behavioural row/column mux model.
module tb_matrix_dot_product_seq;

    localparam int DW  = 8;
    localparam int N   = 2;
    localparam int M   = 2;
    localparam int NSB = 1;
    localparam int ACC = 2*DW + $clog2(N) + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           busy;
    logic           done;
    logic [NSB-1:0] row_select, col_select, result_row, result_col;
    logic [N*DW-1:0] row_data, col_data;
    logic           result_valid;
    logic           result_ready;
    logic [ACC-1:0] result_data;

    logic [DW-1:0] mat_a [M][N];
    logic [DW-1:0] mat_b [N][M];

    typedef struct {
        logic [ACC-1:0] value;
        int             row;
        int             col;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_mode = 0;
    int done_count = 0;

    matrix_dot_product_seq #(
        .DATA_WIDTH(DW), .ROW_COL_SIZE(N), .MATRIX_SIZE(M)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .row_select(row_select), .col_select(col_select),
        .row_data(row_data), .col_data(col_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_row(result_row), .result_col(result_col)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        row_data = '0;
        col_data = '0;
        for (int k = 0; k < N; k++) begin
            row_data[k*DW +: DW] = mat_a[row_select][k];
            col_data[k*DW +: DW] = mat_b[k][col_select];
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    function automatic int elem(input logic [DW-1:0] v);
`ifdef DOT_PRODUCT_SIGNED_EN
        return $signed({{(32-DW){v[DW-1]}}, v});
`else
        return int'({{(32-DW){1'b0}}, v});
`endif
    endfunction

    function automatic logic [ACC-1:0] model_dot(input int r, input int c);
        int s = 0;
        for (int k = 0; k < N; k++) s += elem(mat_a[r][k]) * elem(mat_b[k][c]);
        return ACC'(s);
    endfunction

    // Ready generator: always high, 10-cycle stall per result, or random.
    initial begin
        int hold = 0;
        result_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    if (result_valid && hold < 10) begin
                        result_ready = 1'b0;
                        hold++;
                    end else begin
                        result_ready = 1'b1;
                        if (result_valid) hold = 0;
                    end
                end
                2: result_ready = 1'($urandom_range(0, 1));
                default: result_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks timing and stability.
    initial begin
        bit             prev_stall = 0;
        bit             prev_valid = 0;
        bit             first_pending = 0;
        logic [ACC-1:0] held_data = '0;
        logic [NSB-1:0] held_row = '0, held_col = '0;
        int             start_cyc = 0, last_rise = 0, last_hs = 0;
        exp_t           e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                prev_stall    = 0;
                prev_valid    = 0;
                first_pending = 0;
            end else begin
                if (start && !busy) begin
                    start_cyc     = cyc;
                    first_pending = 1;
                end
                if (result_valid && !prev_valid) begin
                    if (first_pending) begin
                        check("first_latency", 64'(cyc - start_cyc), 64'(N + 2));
                        first_pending = 0;
                    end else if (ready_mode == 0) begin
                        check("pair_spacing", 64'(cyc - last_rise), 64'(N + 2));
                    end
                    last_rise = cyc;
                end
                if (prev_stall) begin
                    check("stall_valid", 64'(result_valid), 64'd1);
                    check("stall_data", 64'(result_data), 64'(held_data));
                    check("stall_row", 64'(result_row), 64'(held_row));
                    check("stall_col", 64'(result_col), 64'(held_col));
                end
                if (result_valid && result_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_result", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_data", 64'(result_data), 64'(e.value));
                        check("result_row", 64'(result_row), 64'(e.row));
                        check("result_col", 64'(result_col), 64'(e.col));
                        check("row_select", 64'(row_select), 64'(e.row));
                        check("col_select", 64'(col_select), 64'(e.col));
                    end
                    last_hs = cyc;
                end
                if (done) begin
                    done_count++;
                    check("done_timing", 64'(cyc - last_hs), 64'd1);
                    check("done_pending", 64'(exp_q.size()), 64'd0);
                    check("done_busy", 64'(busy), 64'd0);
                end
                prev_stall = result_valid && !result_ready;
                prev_valid = result_valid;
                held_data  = result_data;
                held_row   = result_row;
                held_col   = result_col;
            end
        end
    end

    task automatic check_zero(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_valid"}, 64'(result_valid), 64'd0);
        check({name, "_data"}, 64'(result_data), 64'd0);
        check({name, "_row"}, 64'(result_row), 64'd0);
        check({name, "_col"}, 64'(result_col), 64'd0);
        check({name, "_rsel"}, 64'(row_select), 64'd0);
        check({name, "_csel"}, 64'(col_select), 64'd0);
    endtask

    task automatic push_expected();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++)
                exp_q.push_back('{model_dot(r, c), r, c});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run(input int mode, input string name, input int extra_starts);
        int d0 = done_count;
        int n = 0;
        ready_mode = mode;
        push_expected();
        pulse_start();
        for (int i = 0; i < extra_starts; i++) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        while (done_count == d0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done_seen"}, 64'(done_count != d0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_one_done"}, 64'(done_count - d0), 64'd1);
        check({name, "_all_results"}, 64'(exp_q.size()), 64'd0);
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
        exp_q.delete();
    endtask

    task automatic load_basic();
        mat_a[0][0] = 8'd1; mat_a[0][1] = 8'd2; mat_a[1][0] = 8'd3; mat_a[1][1] = 8'd4;
        mat_b[0][0] = 8'd5; mat_b[0][1] = 8'd6; mat_b[1][0] = 8'd7; mat_b[1][1] = 8'd8;
    endtask

    task automatic load_random();
        for (int r = 0; r < M; r++)
            for (int k = 0; k < N; k++) begin
                mat_a[r][k] = DW'($urandom);
                mat_b[k][r] = DW'($urandom);
            end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        load_basic();
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Basic order with known golden values 19, 22, 43, 50.
        load_basic();
        exp_q.push_back('{ACC'(19), 0, 0});
        exp_q.push_back('{ACC'(22), 0, 1});
        exp_q.push_back('{ACC'(43), 1, 0});
        exp_q.push_back('{ACC'(50), 1, 1});
        begin
            int d0 = done_count;
            n = 0;
            ready_mode = 0;
            pulse_start();
            while (done_count == d0 && n < 200) begin
                @(posedge clk);
                n++;
            end
            check("basic_done_seen", 64'(done_count - d0), 64'd1);
            check("basic_results", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end

        run(1, "backpressure", 0);

`ifdef DOT_PRODUCT_SIGNED_EN
        for (int r = 0; r < M; r++) for (int k = 0; k < N; k++) begin
            mat_a[r][k] = 8'h80; mat_b[k][r] = 8'h80;
        end
`else
        for (int r = 0; r < M; r++) for (int k = 0; k < N; k++) begin
            mat_a[r][k] = 8'hFF; mat_b[k][r] = 8'hFF;
        end
`endif
        run(0, "width", 0);

        load_random();
        mat_a[0][0] = 8'hFF; mat_a[0][1] = 8'd2;
        mat_b[0][0] = 8'd3;  mat_b[1][0] = 8'hFC;
        run(2, "mixed_sign", 0);

        // Reset during the MAC phase of pair (1,0).
        load_basic();
        ready_mode = 0;
        push_expected();
        pulse_start();
        n = 0;
        while (!(busy && row_select == 1'b1 && col_select == 1'b0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_pair_1_0", 64'(n < 100), 64'd1);
        @(posedge clk); #2 reset = 1'b1;
        #1 check_zero("midmac_reset");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 check_zero("post_reset");
        run(0, "after_reset", 0);

        load_basic();
        run(1, "start_while_busy", 3);

        for (int t = 0; t < 6; t++) begin
            load_random();
            run(2, "random", 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
